// File: rtl/fpu_pkg.sv
// Shared FPU types and constants: binary32 layout plus the payloads carried
// between the adder's align, add and normalize sections.
package fpu_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } float32_t;

    localparam logic [7:0]  EXP_MAX  = 8'hFF;
    localparam int          EXP_BIAS = 127;
    localparam logic [31:0] QNAN     = 32'h7FC00000;

    // Mantissas are 24 bits plus guard, round and sticky; |ma| >= |mb| after the swap.
    typedef struct packed {
        logic        valid;
        logic        special;
        logic [31:0] spec_val;
        logic        sign;
        logic        op_sub;
        logic [7:0]  exp;
        logic [26:0] ma;
        logic [26:0] mb;
    } align_t;

    typedef struct packed {
        logic        valid;
        logic        special;
        logic [31:0] spec_val;
        logic        sign;
        logic        op_sub;
        logic [7:0]  exp;
        logic [27:0] sum;
    } add_t;

    // exp is two's complement so that underflow below 1 is visible.
    typedef struct packed {
        logic        valid;
        logic        special;
        logic [31:0] spec_val;
        logic        sign;
        logic        flush;
        logic [9:0]  exp;
        logic [26:0] man;
    } norm_t;

endpackage

// File: rtl/fpu_lzc.sv
// Combinational 27-bit leading-zero counter shared by the FPU normalizers.
// An all-zero input reports 27.
module fpu_lzc (
    input  logic [26:0] data,
    output logic [4:0]  count
);

    // Ascending scan: the highest set bit is the last one to write count.
    always_comb begin
        count = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (data[i]) begin
                count = 5'(26 - i);
            end
        end
    end

endmodule

// File: rtl/fadd_pipe.sv
// Handshaked binary32 adder with 1..4 cycle latency and round-to-nearest-even.
// Define FADD_PIPE_SUB_EN to honour the sub input (x1 - x2); otherwise add-only.
module fadd_pipe
    import fpu_pkg::*;
#(
    parameter int NSTAGE = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    input  logic        sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        ovf
);

    logic        adv;
    logic [31:0] x2e;
    float32_t    f1, f2, fa, fb;
    logic        swap;
    logic [23:0] ma, mb;
    logic [7:0]  dexp;
    logic [26:0] bext, bsh, lost_mask;
    logic [4:0]  lz;
    logic        round_up;
    logic [24:0] mr;
    logic [9:0]  exp_r;
    logic [31:0] y_c;
    logic        ovf_c;

    align_t align_c, align_q;
    add_t   add_c, add_q;
    norm_t  norm_c, norm_q;

    assign adv      = !out_valid | out_ready;
    assign in_ready = adv;

`ifdef FADD_PIPE_SUB_EN
    assign x2e = {x2[31] ^ sub, x2[30:0]};
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign x2e        = x2;
`endif

    // Denormals compare and add as zero, so their magnitude is forced to 0.
    always_comb begin
        f1        = x1;
        f2        = x2e;
        swap      = ((f2.exp == 8'd0) ? 31'd0 : x2e[30:0]) >
                    ((f1.exp == 8'd0) ? 31'd0 : x1[30:0]);
        fa        = swap ? f2 : f1;
        fb        = swap ? f1 : f2;
        ma        = (fa.exp == 8'd0) ? 24'd0 : {1'b1, fa.man};
        mb        = (fb.exp == 8'd0) ? 24'd0 : {1'b1, fb.man};
        dexp      = fa.exp - fb.exp;
        bext      = {mb, 3'b000};
        lost_mask = '0;
        if (dexp >= 8'd27) begin
            bsh = {26'd0, |bext};
        end else begin
            lost_mask = ~(27'h7FFFFFF << dexp);
            bsh       = bext >> dexp;
            bsh[0]    = bsh[0] | (|(bext & lost_mask));
        end

        align_c        = '0;
        align_c.valid  = in_valid;
        align_c.sign   = fa.sign;
        align_c.op_sub = fa.sign ^ fb.sign;
        align_c.exp    = fa.exp;
        align_c.ma     = {ma, 3'b000};
        align_c.mb     = bsh;
        if (f1.exp == EXP_MAX) begin
            align_c.special  = 1'b1;
            align_c.spec_val = (f2.exp == EXP_MAX && f1.man == 23'd0 && f2.man == 23'd0 &&
                                f1.sign != f2.sign) ? QNAN : x1;
        end else if (f2.exp == EXP_MAX) begin
            align_c.special  = 1'b1;
            align_c.spec_val = x2e;
        end
    end

    always_comb begin
        add_c          = '0;
        add_c.valid    = align_q.valid;
        add_c.special  = align_q.special;
        add_c.spec_val = align_q.spec_val;
        add_c.sign     = align_q.sign;
        add_c.op_sub   = align_q.op_sub;
        add_c.exp      = align_q.exp;
        add_c.sum      = align_q.op_sub ? ({1'b0, align_q.ma} - {1'b0, align_q.mb})
                                        : ({1'b0, align_q.ma} + {1'b0, align_q.mb});
    end

    fpu_lzc u_lzc (
        .data  (add_q.sum[26:0]),
        .count (lz)
    );

    // A zero sum from opposite-signed operands is +0; same-signed zeros keep their sign.
    always_comb begin
        norm_c          = '0;
        norm_c.valid    = add_q.valid;
        norm_c.special  = add_q.special;
        norm_c.spec_val = add_q.spec_val;
        if (add_q.sum[27]) begin
            norm_c.man = {add_q.sum[27:2], add_q.sum[1] | add_q.sum[0]};
            norm_c.exp = {2'b00, add_q.exp} + 10'd1;
        end else begin
            norm_c.man = add_q.sum[26:0] << lz;
            norm_c.exp = {2'b00, add_q.exp} - {5'd0, lz};
        end
        norm_c.flush = (add_q.sum == 28'd0) || ($signed(norm_c.exp) <= 10'sd0);
        norm_c.sign  = (add_q.sum == 28'd0 && add_q.op_sub) ? 1'b0 : add_q.sign;
    end

    always_comb begin
        round_up = norm_q.man[2] & (norm_q.man[1] | norm_q.man[0] | norm_q.man[3]);
        mr       = {1'b0, norm_q.man[26:3]} + {24'd0, round_up};
        exp_r    = norm_q.exp + {9'd0, mr[24]};
        y_c      = '0;
        ovf_c    = 1'b0;
        if (norm_q.special) begin
            y_c = norm_q.spec_val;
        end else if (norm_q.flush) begin
            y_c = {norm_q.sign, 31'd0};
        end else if (exp_r >= 10'd255) begin
            y_c   = {norm_q.sign, EXP_MAX, 23'd0};
            ovf_c = 1'b1;
        end else begin
            y_c = {norm_q.sign, exp_r[7:0], mr[24] ? mr[23:1] : mr[22:0]};
        end
    end

    generate
        if (NSTAGE >= 2) begin : g_align_reg
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)    align_q <= '0;
                else if (adv) align_q <= align_c;
            end
        end else begin : g_align_pass
            assign align_q = align_c;
        end

        if (NSTAGE >= 3) begin : g_add_reg
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)    add_q <= '0;
                else if (adv) add_q <= add_c;
            end
        end else begin : g_add_pass
            assign add_q = add_c;
        end

        if (NSTAGE >= 4) begin : g_norm_reg
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)    norm_q <= '0;
                else if (adv) norm_q <= norm_c;
            end
        end else begin : g_norm_pass
            assign norm_q = norm_c;
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            y         <= '0;
            ovf       <= 1'b0;
        end else if (adv) begin
            out_valid <= norm_q.valid;
            if (norm_q.valid) begin
                y   <= y_c;
                ovf <= ovf_c;
            end
        end
    end

endmodule

// File: tb/tb_fadd_pipe.sv
// Directed bench for fadd_pipe: one instance per NSTAGE (1..4) checked against
// hand-computed vectors, back-pressure ordering and mid-operation reset.
module tb_fadd_pipe;
    import fpu_pkg::*;

    localparam int NDUT = 4;
    localparam logic [31:0] ONE = {1'b0, 8'(EXP_BIAS), 23'd0};
`ifdef FADD_PIPE_SUB_EN
    localparam logic [31:0] SUB_Y1 = 32'h40000000;
    localparam logic [31:0] SUB_Y2 = 32'h00000000;
`else
    localparam logic [31:0] SUB_Y1 = 32'h40800000;
    localparam logic [31:0] SUB_Y2 = 32'h40000000;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] y;
        logic        ovf;
    } vec_t;

    logic             clk = 1'b0;
    logic             rstn;
    logic             in_valid;
    logic [31:0]      x1, x2;
    logic             sub;
    logic             out_ready;
    logic [3:0]       en;
    logic [3:0]       in_ready, out_valid, ovf;
    logic [3:0][31:0] y;
    int               n_checks = 0;
    int               n_fail   = 0;
    vec_t             vecs[18];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        fadd_pipe #(.NSTAGE(g + 1)) dut (
            .clk       (clk),
            .rstn      (rstn),
            .in_valid  (in_valid & en[g]),
            .in_ready  (in_ready[g]),
            .x1        (x1),
            .x2        (x2),
            .sub       (sub),
            .out_valid (out_valid[g]),
            .out_ready (out_ready),
            .y         (y[g]),
            .ovf       (ovf[g])
        );
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // One operation through every instance; latency counted in cycles after accept.
    task automatic apply_stimulus(input vec_t v, input int idx);
        int          lat [NDUT];
        logic [31:0] cy  [NDUT];
        logic        cov [NDUT];
        for (int g = 0; g < NDUT; g++) begin
            lat[g] = 0;
            cy[g]  = '0;
            cov[g] = 1'b0;
        end
        @(negedge clk);
        x1 = v.a; x2 = v.b; sub = v.sub; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            for (int g = 0; g < NDUT; g++) begin
                if (lat[g] == 0 && out_valid[g]) begin
                    lat[g] = c;
                    cy[g]  = y[g];
                    cov[g] = ovf[g];
                end
            end
            @(negedge clk);
        end
        for (int g = 0; g < NDUT; g++) begin
            check_output($sformatf("vec%0d_y_n%0d", idx, g + 1), cy[g], v.y);
            check_output($sformatf("vec%0d_ovf_n%0d", idx, g + 1), 32'(cov[g]), 32'(v.ovf));
            check_output($sformatf("vec%0d_latency_n%0d", idx, g + 1), 32'(lat[g]), 32'(g + 1));
        end
    endtask

    // Six back-to-back operations with out_ready low for three cycles mid-stream.
    task automatic backpressure_test(input int g);
        logic [31:0] ops [6];
        logic [31:0] res [6];
        int          sent = 0;
        int          rcv  = 0;
        logic        prev_stall = 1'b0;
        logic [31:0] prev_y = '0;
        ops = '{32'h3F800000, 32'h40000000, 32'h40400000,
                32'h40800000, 32'h40A00000, 32'h40C00000};
        res = '{32'h40000000, 32'h40400000, 32'h40800000,
                32'h40A00000, 32'h40C00000, 32'h40E00000};
        en  = 4'(1 << g);
        for (int c = 0; c < 40 && rcv < 6; c++) begin
            @(negedge clk);
            out_ready = !(c >= 4 && c <= 6);
            in_valid  = (sent < 6);
            x1        = '0;
            if (sent < 6) x1 = ops[sent];
            x2  = ONE;
            sub = 1'b0;
            #1;
            if (!out_ready && out_valid[g]) begin
                check_output($sformatf("bp_n%0d_in_ready_stall", g + 1), 32'(in_ready[g]), 32'd0);
                if (prev_stall)
                    check_output($sformatf("bp_n%0d_y_hold", g + 1), y[g], prev_y);
                prev_stall = 1'b1;
                prev_y     = y[g];
            end else begin
                prev_stall = 1'b0;
            end
            if (in_valid && in_ready[g]) sent++;
            if (out_valid[g] && out_ready) begin
                if (rcv < 6)
                    check_output($sformatf("bp_n%0d_res%0d", g + 1, rcv), y[g], res[rcv]);
                rcv++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_output($sformatf("bp_n%0d_count", g + 1), 32'(rcv), 32'd6);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            check_output($sformatf("bp_n%0d_no_extra", g + 1), 32'(out_valid[g]), 32'd0);
        end
        en = 4'hF;
    endtask

    initial begin
        rstn = 1'b0; in_valid = 1'b0; x1 = '0; x2 = '0; sub = 1'b0;
        out_ready = 1'b1; en = 4'hF;

        vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0};
        vecs[1]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1};
        vecs[2]  = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 1'b0};
        vecs[3]  = '{32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 1'b0};
        vecs[4]  = '{32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 1'b0};
        vecs[5]  = '{32'h4B800000, 32'h3FC00000, 1'b0, 32'h4B800001, 1'b0};
        vecs[6]  = '{32'h4B800001, 32'h3F800000, 1'b0, 32'h4B800002, 1'b0};
        vecs[7]  = '{32'h3F800000, 32'hC0000000, 1'b0, 32'hBF800000, 1'b0};
        vecs[8]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0};
        vecs[9]  = '{32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
        vecs[10] = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 1'b0};
        vecs[11] = '{32'h3F800000, 32'hFF800000, 1'b0, 32'hFF800000, 1'b0};
        vecs[12] = '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0};
        vecs[13] = '{32'h80C00000, 32'h00800000, 1'b0, 32'h80000000, 1'b0};
        vecs[14] = '{32'h4B800000, 32'h33800000, 1'b0, 32'h4B800000, 1'b0};
        vecs[15] = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0};
        vecs[16] = '{32'h40400000, 32'h3F800000, 1'b1, SUB_Y1, 1'b0};
        vecs[17] = '{32'h3F800000, 32'h3F800000, 1'b1, SUB_Y2, 1'b0};

        repeat (2) @(negedge clk);
        for (int g = 0; g < NDUT; g++) begin
            check_output($sformatf("rst_out_valid_n%0d", g + 1), 32'(out_valid[g]), 32'd0);
            check_output($sformatf("rst_y_n%0d", g + 1), y[g], 32'd0);
            check_output($sformatf("rst_ovf_n%0d", g + 1), 32'(ovf[g]), 32'd0);
            check_output($sformatf("rst_in_ready_n%0d", g + 1), 32'(in_ready[g]), 32'd1);
        end
        rstn = 1'b1;

        for (int i = 0; i < 18; i++) apply_stimulus(vecs[i], i);
        for (int g = 0; g < NDUT; g++) backpressure_test(g);

        // Fill every pipeline, stall the outputs, then pulse reset between edges.
        @(negedge clk);
        x1 = 32'h7F7FFFFF; x2 = 32'h7F7FFFFF; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        x1 = ONE; x2 = ONE;
        @(negedge clk);
        x1 = 32'h40400000; x2 = ONE;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check_output("pre_rst_out_valid", 32'(out_valid), 32'hF);
        check_output("pre_rst_ovf_n4", 32'(ovf[3]), 32'd1);
        #1 rstn = 1'b0;
        #1;
        for (int g = 0; g < NDUT; g++) begin
            check_output($sformatf("midrst_out_valid_n%0d", g + 1), 32'(out_valid[g]), 32'd0);
            check_output($sformatf("midrst_y_n%0d", g + 1), y[g], 32'd0);
            check_output($sformatf("midrst_ovf_n%0d", g + 1), 32'(ovf[g]), 32'd0);
        end
        #1 rstn = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check_output("post_rst_no_stale", 32'(out_valid), 32'd0);
        end
        apply_stimulus(vecs[0], 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fadd_pipe.md
# fadd_pipe

Parametrised, handshaked IEEE-754 single-precision adder/subtractor with configurable pipeline depth. It replaces the fixed two-stage `fadd` in the FPU. It adds valid/ready flow control with back-pressure, an optional subtract mode, and round-to-nearest-even. It sits between the FPU issue logic and the writeback arbiter.

## Interface
- `NSTAGE`, 2: latency in cycles from input accept to `out_valid`; legal range 1..4.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  pipeline can accept this cycle.
- `x1`  in  32  operand 1, binary32.
- `x2`  in  32  operand 2, binary32.
- `sub`  in  1  1 = compute x1 − x2. Ignored unless `FADD_PIPE_SUB_EN` is defined.
- `out_valid`  out  1  `y`/`ovf` valid.
- `out_ready`  in  1  consumer accepts the result this cycle.
- `y`  out  32  result, binary32.
- `ovf`  out  1  overflow: both inputs finite (exponent < 255) and the result exponent is 255.

## Operation
- Effective operand: `x2e = x2 ^ {sub_en & sub, 31'b0}`.
- Denormal inputs (exponent 0) are treated as signed zero.
- A result below the normal range flushes to +0 or −0, keeping the computed sign.
- Special operands:
  - Either input with exponent 255 forces the result to that input (x1 takes priority); `ovf` = 0.
  - inf + (−inf) returns 0x7FC00000.
- Exact cancellation (x + (−x)) returns +0.
- (−0) + (−0) returns −0.
- Datapath sections, in order:
  - Align: exponent compare, swap so |a| ≥ |b|, right-shift b with guard, round and sticky bits (sticky = OR of all shifted-out bits).
  - Add: 27-bit add or subtract.
  - Normalize: leading-zero count, then left shift, or a 1-bit right shift on carry-out.
  - Round: round-to-nearest-even. A mantissa carry increments the exponent. An exponent reaching 255 gives ±inf with `ovf` = 1.
- Pipeline registers:
  - Output register (`y`, `ovf`, `out_valid`): always present.
  - After align: present if NSTAGE ≥ 2.
  - After add: present if NSTAGE ≥ 3.
  - After normalize: present if NSTAGE = 4.
- Each stage register carries its own valid bit.

## Timing
- Global advance: `adv = !out_valid | out_ready`. All stage registers load only when `adv` = 1.
- `in_ready = adv`. A transfer occurs when `in_valid & in_ready`.
- Result latency: a result accepted at edge k appears with `out_valid` = 1 after edge k+NSTAGE−1, i.e. NSTAGE cycles after input sampling. This holds only if no stall occurs in between. Each stall cycle adds exactly one cycle.
- Throughput: one result per cycle while `out_ready` = 1.
- Bubbles (`in_valid` = 0 on an accepted cycle) propagate as valid = 0 and do not consume a result slot.
- While stalled, `y`, `ovf` and `out_valid` hold steady, and all internal stages hold. Ordering is strictly FIFO.
- Reset: asserting `rstn` low immediately clears every stage valid, `out_valid`, `y` (0x00000000) and `ovf` (0). This applies mid-operation too: in-flight results are discarded, and none appear after release.
- First acceptance after reset: on the first edge with `rstn` high.
- `in_ready` depends combinationally on `out_ready`. No other combinational path runs from input to output.

## Configuration
- `FADD_PIPE_SUB_EN` defined:
  - `sub` is honoured (sub_en = 1).
  - `sub` is pipelined only through the align section.
- `FADD_PIPE_SUB_EN` undefined:
  - sub_en = 0; the block is add-only.
  - `sub` is unconnected internally.
  - Area drops by the sign XOR and its related register bit.

## Structure
- Shared package `fpu_pkg`:
  - `float32_t` packed struct {sign, exp[7:0], man[22:0]}.
  - Constants `EXP_MAX` = 8'hFF, `EXP_BIAS` = 127, `QNAN` = 32'h7FC00000.
  - Per-stage payload structs.
- One sub-module, `fpu_lzc`: a combinational 27-bit leading-zero counter, also reused by fmul/fdiv normalization.
- Stage registers are generate-selected by NSTAGE inside `fadd_pipe`.

## Test plan
- 0x3F800000 + 0x3F800000, `out_ready` = 1 → y = 0x40000000, ovf = 0, `out_valid` exactly NSTAGE cycles after accept. Run for NSTAGE = 1..4.
- 0x7F7FFFFF + 0x7F7FFFFF → y = 0x7F800000, ovf = 1. Also 0x7F800000 + 0x3F800000 → y = 0x7F800000, ovf = 0.
- Rounding and cancellation: 0x4B800000 + 0x3F800000 (tie) → y = 0x4B800000. 0x3F800000 + 0xBF800000 → y = 0x00000000.
- Back-pressure: six back-to-back operand pairs with `out_ready` low for 3 cycles mid-stream → six results in order, none duplicated, `in_ready` = 0 during the stall, outputs stable.
- Reset mid-operation: pipeline full, `rstn` low for 1 cycle between edges → `out_valid` = 0, y = 0, ovf = 0 immediately, no stale results after release.
- Subtract mode, `FADD_PIPE_SUB_EN` defined: 0x40400000 − 0x3F800000, sub = 1 → y = 0x40000000. Same stimulus with the macro undefined → y = 0x40800000.
